// File: rtl/cordic_sched_pkg.sv
// Shared types and helpers for the CORDIC request scheduler.
// State encoding, default watchdog length and ID sizing.
package cordic_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam int DEF_TIMEOUT = 64;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr,
// wrapping, wins. Grant is one-hot, idx is its encoded position.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   always_comb begin
      logic          found;
      logic [IW:0]   s;
      logic [IW-1:0] p;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      s     = '0;
      p     = '0;
      for (int i = 0; i < N; i++) begin
         s = {1'b0, ptr} + (IW+1)'(i);
         if (s >= (IW+1)'(N))
            s = s - (IW+1)'(N);
         p = s[IW-1:0];
         if (en && !found && req[p]) begin
            found    = 1'b1;
            grant[p] = 1'b1;
            idx      = p;
         end
      end
   end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one iterative CORDIC engine among NUM_REQ requesters,
// with round-robin grant, watchdog abort and a single response channel.
module cordic_scheduler
   import cordic_sched_pkg::*;
#(
   parameter int  NUM_REQ     = 4,
   parameter int  WIDTH       = 16,
   parameter int  ANGLE_WIDTH = 32,
   parameter int  TIMEOUT     = DEF_TIMEOUT,
   localparam int ID_W        = id_width(NUM_REQ)
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
   input  logic [NUM_REQ*WIDTH-1:0]       req_x,
   input  logic [NUM_REQ*WIDTH-1:0]       req_y,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [ID_W-1:0]                rsp_id,
   output logic [WIDTH-1:0]               rsp_cos,
   output logic [WIDTH-1:0]               rsp_sin,
   output logic                           rsp_err,
   output logic                           cor_start,
   output logic [ANGLE_WIDTH-1:0]         cor_angle,
   output logic [WIDTH-1:0]               cor_x,
   output logic [WIDTH-1:0]               cor_y,
   input  logic                           cor_done,
   input  logic [WIDTH-1:0]               cor_cos,
   input  logic [WIDTH-1:0]               cor_sin,
   output logic                           busy,
   output logic                           spurious_done
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t            state_q, state_n;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   gidx;
   logic [NUM_REQ-1:0] grant;
   logic [CW-1:0]     cnt_q;
   logic              hs;
   logic              expire;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .en    (state_q == IDLE),
      .grant (grant),
      .idx   (gidx)
   );

   assign req_ready = grant;
   assign hs        = |grant;
   assign expire    = (cnt_q == CNT_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE:  if (hs) state_n = ISSUE;
         ISSUE: state_n = WAIT;
         WAIT:  if (cor_done || expire) state_n = RESP;
         RESP:  if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Status outputs are flopped from the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cor_start <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cor_start <= (state_n == ISSUE);
         rsp_valid <= (state_n == RESP);
         busy      <= (state_n != IDLE);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q         <= '0;
         cnt_q         <= '0;
         cor_angle     <= '0;
         cor_x         <= '0;
         cor_y         <= '0;
         rsp_id        <= '0;
         rsp_cos       <= '0;
         rsp_sin       <= '0;
         rsp_err       <= 1'b0;
         spurious_done <= 1'b0;
      end else begin
         if (hs) begin
            cor_angle <= req_angle[gidx*ANGLE_WIDTH +: ANGLE_WIDTH];
            cor_x     <= req_x[gidx*WIDTH +: WIDTH];
            cor_y     <= req_y[gidx*WIDTH +: WIDTH];
            rsp_id    <= gidx;
            ptr_q     <= (gidx == ID_W'(NUM_REQ - 1)) ? '0
                                                        : gidx + ID_W'(1);
         end
         if (state_q == ISSUE)
            cnt_q <= '0;
         else if (state_q == WAIT)
            cnt_q <= cnt_q + CW'(1);
         if (state_q == WAIT) begin
            if (cor_done) begin
               rsp_cos <= cor_cos;
               rsp_sin <= cor_sin;
               rsp_err <= 1'b0;
            end else if (expire) begin
               rsp_cos <= '0;
               rsp_sin <= '0;
               rsp_err <= 1'b1;
            end
         end
         if (cor_done && state_q != WAIT)
            spurious_done <= 1'b1;
      end
   end

endmodule

// File: doc/cordic_scheduler.md
# cordic_scheduler

Time-shares one iterative CORDIC sine/cosine engine among `NUM_REQ` requesters. The block accepts angle/vector requests over per-port valid/ready handshakes, grants round-robin, and pulses the engine's start. It captures the engine's one-cycle done result and returns it with the requester ID on a single response channel. It sits between the requesting datapaths and the shared engine, and the engine is used only through this block.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 16: coordinate/result width, signed.
- `ANGLE_WIDTH`, 32: angle width, signed fixed point as used by the engine.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the request is aborted (≥4).
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width (derived, not overridden).

Ports:
- `clock` in 1: sole clock. One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept, at most one bit high.
- `req_angle` in NUM_REQ*ANGLE_WIDTH: packed angles, requester i at slice i.
- `req_x` in NUM_REQ*WIDTH: packed x_start.
- `req_y` in NUM_REQ*WIDTH: packed y_start.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out ID_W: requester index of the response.
- `rsp_cos`, `rsp_sin` out WIDTH: captured results.
- `rsp_err` out 1: response aborted by timeout; results are 0.
- `cor_start` out 1: one-cycle start pulse to engine.
- `cor_angle` out ANGLE_WIDTH, `cor_x`, `cor_y` out WIDTH: registered operands.
- `cor_done` in 1: engine done pulse.
- `cor_cos`, `cor_sin` in WIDTH: engine results, valid while `cor_done`=1.
- `busy` out 1: state ≠ IDLE.
- `spurious_done` out 1: sticky flag, set when `cor_done` arrives outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready` is the one-hot round-robin grant over `req_valid`, searching from pointer `ptr` upward with wrap. If a handshake occurs on port g, latch that port's operands into `cor_*`, latch g into `rsp_id`, set `ptr` to (g+1) mod NUM_REQ, and go to ISSUE. `ptr` is unchanged when nothing is granted.
- `req_ready` is 0 in every state other than IDLE.
- ISSUE: `cor_start`=1 for exactly this cycle, watchdog counter cleared, then go to WAIT.
- WAIT: the counter increments each cycle.
  - `cor_done`=1: capture `cor_cos`/`cor_sin`, set `rsp_err`=0, go to RESP.
  - Counter reaches TIMEOUT-1 without done: set results to 0, `rsp_err`=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP: `rsp_valid`=1. All `rsp_*` outputs stay stable until `rsp_ready`, then go to IDLE.
- `cor_angle`/`cor_x`/`cor_y` hold from the grant until the next grant.
- `cor_done` in IDLE, ISSUE or RESP is ignored for data and sets `spurious_done`. The flag clears only on reset.
- Requester inputs are sampled only in the handshake cycle. A requester may drop `req_valid` without penalty while not granted.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_cos`/`rsp_sin`=0, `rsp_err`=0, `cor_start`=0, `cor_*` operands=0, `busy`=0, `spurious_done`=0, `ptr`=0, state IDLE.
- Reset mid-operation discards the in-flight request with no response. Engine reset is driven by the top level.

## Timing
- Handshake at cycle T → `cor_start` high at T+1 → WAIT from T+2.
- `cor_done` seen at cycle D → `rsp_valid` high at D+1.
- Earliest next grant is in the cycle after the `rsp_ready` handshake.
- Timeout: with no done, `rsp_valid` rises at T+2+TIMEOUT.
- Exactly one outstanding engine operation at any time.
- `req_ready` is combinational from `req_valid`, `ptr` and state. All other outputs are registered.

## Structure
- Package `cordic_sched_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), ID-width helper function, default TIMEOUT constant.
- Sub-module `rr_arbiter` (NUM_REQ): inputs request vector, pointer and enable; outputs one-hot grant and encoded index. Combinational, reused elsewhere.

## Test plan
- Single request: port 2 with angle=0, x=0x26DD, y=0. Model done at T+20 with cos=0x26DD, sin=0 → `rsp_valid` at T+21, `rsp_id`=2, `rsp_err`=0, `cor_start` high for exactly one cycle.
- All four ports valid continuously → grant order 0,1,2,3,0. Each response ID matches its grant. Operands are stable throughout WAIT.
- Model never asserts done with TIMEOUT=64 → `rsp_valid` at T+66, `rsp_err`=1, cos/sin=0. The next request is then served normally.
- Backpressure: `rsp_ready` held low for 10 cycles → response fields stable, `req_ready` all 0, no second `cor_start`.
- `cor_done` pulsed while in IDLE → `spurious_done`=1, no response, state unchanged.
- `reset_n` low during WAIT → all outputs return to reset values immediately, `ptr`=0, and a later done from the engine sets only `spurious_done`.
